// File: rtl/req_dispatch_pkg.sv
// Shared definitions for the request dispatcher: state encodings, counter
// widths and the address-offset helper.
package req_dispatch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_WAIT    = 2'd2;
    localparam state_t ST_DELIVER = 2'd3;

    localparam int unsigned TMO_W = 8;

    function automatic int unsigned offset_bits(input int unsigned cl_size);
        return $clog2(cl_size / 8);
    endfunction

endpackage

// File: rtl/req_dispatch.sv
// Drains the cache instruction queue one entry at a time: issues a
// line-aligned memory request, retries NACKs, bounds the wait, delivers.
module req_dispatch
    import req_dispatch_pkg::*;
#(
    parameter int unsigned CL_SIZE   = 128,
    parameter int unsigned RETRY_MAX = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_valid,
    input  logic [31:0]        q_addr,
    input  logic [2:0]         q_op,
    input  logic [1:0]         q_src,
    input  logic [1:0]         q_dest,
    input  logic               q_is_flush,
    output logic               q_dealloc,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [31:0]        mem_addr,
    output logic [2:0]         mem_op,
    output logic               mem_flush,
    output logic [1:0]         mem_tag,
    input  logic               mem_resp_valid,
    input  logic               mem_resp_nack,
    input  logic [CL_SIZE-1:0] mem_resp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_src,
    output logic [1:0]         out_dest,
    output logic [CL_SIZE-1:0] out_data,
    output logic               out_err,
    output logic               busy
);

    localparam int unsigned     OFF        = offset_bits(CL_SIZE);
    localparam logic [31:0]     ADDR_MASK  = ~((32'd1 << OFF) - 32'd1);
    localparam int unsigned     RTY_W      = $clog2(RETRY_MAX + 1);
    localparam logic [RTY_W-1:0] RETRY_LAST = RTY_W'(RETRY_MAX - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);

    state_t               r_state;
    logic [31:0]          r_addr;
    logic [2:0]           r_op;
    logic [1:0]           r_src;
    logic [1:0]           r_dest;
    logic                 r_flush;
    logic [RTY_W-1:0]     r_retry;
    logic [TMO_W-1:0]     r_tmo;
    logic                 r_req_valid;
    logic                 r_out_valid;
    logic [1:0]           r_out_src;
    logic [1:0]           r_out_dest;
    logic [CL_SIZE-1:0]   r_out_data;
    logic                 r_out_err;
    logic                 r_busy;

    state_t w_state_nxt;
    logic   w_resp;
    logic   w_ack;
    logic   w_nack;
    logic   w_retry_last;
    logic   w_tmo_exp;
    logic   w_err_enter;

    assign w_resp       = mem_resp_valid && (r_state == ST_WAIT);
    assign w_ack        = w_resp && !mem_resp_nack;
    assign w_nack       = w_resp && mem_resp_nack;
    assign w_retry_last = (r_retry == RETRY_LAST);
    // Expiry is the TIMEOUT-th WAIT cycle; a response in that cycle wins.
    assign w_tmo_exp    = (r_tmo == TMO_LAST);
    assign w_err_enter  = (r_state == ST_WAIT) &&
                          ((w_nack && w_retry_last) || (!w_resp && w_tmo_exp));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (q_valid)       w_state_nxt = ST_ISSUE;
            ST_ISSUE:   if (mem_req_ready) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_ack)
                    w_state_nxt = r_flush ? ST_IDLE : ST_DELIVER;
                else if (w_nack)
                    w_state_nxt = w_retry_last ? ST_DELIVER : ST_ISSUE;
                else if (w_tmo_exp)
                    w_state_nxt = ST_DELIVER;
            end
            ST_DELIVER: if (out_ready)     w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_op        <= '0;
            r_src       <= '0;
            r_dest      <= '0;
            r_flush     <= 1'b0;
            r_retry     <= '0;
            r_tmo       <= '0;
            r_req_valid <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_out_dest  <= '0;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_valid <= (w_state_nxt == ST_ISSUE);
            r_out_valid <= (w_state_nxt == ST_DELIVER);
            r_busy      <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (q_valid) begin
                        r_addr    <= q_addr & ADDR_MASK;
                        r_op      <= q_op;
                        r_src     <= q_src;
                        r_dest    <= q_dest;
                        r_flush   <= q_is_flush;
                        r_retry   <= '0;
                        r_tmo     <= '0;
                        r_out_err <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (mem_req_ready)
                        r_tmo <= '0;
                end
                ST_WAIT: begin
                    r_tmo <= r_tmo + 1'b1;
                    if (w_nack && !w_retry_last)
                        r_retry <= r_retry + 1'b1;
                    if (w_ack && !r_flush) begin
                        r_out_data <= mem_resp_data;
                        r_out_err  <= 1'b0;
                        r_out_src  <= r_src;
                        r_out_dest <= r_dest;
                    end else if (w_err_enter) begin
                        r_out_data <= '0;
                        r_out_err  <= 1'b1;
                        r_out_src  <= r_src;
                        r_out_dest <= r_dest;
                    end
                end
                ST_DELIVER: begin
                    if (out_ready)
                        r_out_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Pop is the only combinational output: it must land in the retiring cycle.
    assign q_dealloc = (w_ack && r_flush) ||
                       ((r_state == ST_DELIVER) && r_out_valid && out_ready);

    assign mem_req_valid = r_req_valid;
    assign mem_addr      = r_addr;
    assign mem_op        = r_op;
    assign mem_flush     = r_flush;
    assign mem_tag       = r_src;
    assign out_valid     = r_out_valid;
    assign out_src       = r_out_src;
    assign out_dest      = r_out_dest;
    assign out_data      = r_out_data;
    assign out_err       = r_out_err;
    assign busy          = r_busy;

endmodule

// File: tb/tb_req_dispatch.sv
// Directed bench for req_dispatch: best case, flush, NACK retry, timeout,
// backpressure and mid-flight reset.
module tb_req_dispatch;

    logic         clk;
    logic         rst;
    logic         q_valid;
    logic [31:0]  q_addr;
    logic [2:0]   q_op;
    logic [1:0]   q_src;
    logic [1:0]   q_dest;
    logic         q_is_flush;
    logic         q_dealloc;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_addr;
    logic [2:0]   mem_op;
    logic         mem_flush;
    logic [1:0]   mem_tag;
    logic         mem_resp_valid;
    logic         mem_resp_nack;
    logic [127:0] mem_resp_data;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_src;
    logic [1:0]   out_dest;
    logic [127:0] out_data;
    logic         out_err;
    logic         busy;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned n_dealloc = 0;
    int unsigned n_req = 0;

    req_dispatch #(
        .CL_SIZE   (128),
        .RETRY_MAX (4),
        .TIMEOUT   (255)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .q_valid        (q_valid),
        .q_addr         (q_addr),
        .q_op           (q_op),
        .q_src          (q_src),
        .q_dest         (q_dest),
        .q_is_flush     (q_is_flush),
        .q_dealloc      (q_dealloc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_op         (mem_op),
        .mem_flush      (mem_flush),
        .mem_tag        (mem_tag),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_nack  (mem_resp_nack),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_src        (out_src),
        .out_dest       (out_dest),
        .out_data       (out_data),
        .out_err        (out_err),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (q_dealloc) n_dealloc++;
        if (mem_req_valid && mem_req_ready) n_req++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] op,
                        input logic [1:0] src, input logic [1:0] dest, input logic fl);
        q_valid    = 1'b1;
        q_addr     = a;
        q_op       = op;
        q_src      = src;
        q_dest     = dest;
        q_is_flush = fl;
    endtask

    task automatic test_reset();
        logic [174:0] outs;
        rst = 1'b1;
        q_valid = 0; q_addr = '0; q_op = '0; q_src = '0; q_dest = '0; q_is_flush = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_nack = 0; mem_resp_data = '0;
        out_ready = 0;
        repeat (2) tick();
        outs = {q_dealloc, mem_req_valid, mem_addr, mem_op, mem_flush, mem_tag,
                out_valid, out_src, out_dest, out_data, out_err, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_best_case();
        int unsigned d0 = n_dealloc;
        int unsigned r0 = n_req;
        logic [127:0] d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        load(32'h0000_1237, 3'b101, 2'd2, 2'd1, 1'b0);
        mem_req_ready = 1; out_ready = 1;
        tick();  // cycle 1: ISSUE
        checks++;
        if ({mem_req_valid, busy} !== 2'b11) begin errors++; $display("FAIL best_issue: got %b want 11", {mem_req_valid, busy}); end
        checks++;
        if (mem_addr !== 32'h0000_1230) begin errors++; $display("FAIL best_mem_addr: got %h want 00001230", mem_addr); end
        checks++;
        if ({mem_op, mem_tag, mem_flush} !== {3'b101, 2'd2, 1'b0}) begin
            errors++; $display("FAIL best_fields: got %b want 101100", {mem_op, mem_tag, mem_flush});
        end
        tick();  // cycle 2: WAIT
        checks++;
        if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL best_wait_req: got %b want 0", mem_req_valid); end
        mem_resp_valid = 1; mem_resp_nack = 0; mem_resp_data = d;
        #1;
        checks++;
        if (q_dealloc !== 1'b0) begin errors++; $display("FAIL best_wait_dealloc: got %b want 0", q_dealloc); end
        tick();  // cycle 3: DELIVER
        mem_resp_valid = 0;
        checks++;
        if ({out_valid, out_err, out_src, out_dest} !== {1'b1, 1'b0, 2'd2, 2'd1}) begin
            errors++; $display("FAIL best_deliver: got %b want 101001", {out_valid, out_err, out_src, out_dest});
        end
        checks++;
        if (out_data !== d) begin errors++; $display("FAIL best_out_data: got %h want %h", out_data, d); end
        checks++;
        if (q_dealloc !== 1'b1) begin errors++; $display("FAIL best_dealloc: got %b want 1", q_dealloc); end
        q_valid = 0;
        tick();  // cycle 4: IDLE
        checks++;
        if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL best_idle: got %b want 00", {out_valid, busy}); end
        checks++;
        if (n_dealloc - d0 != 1 || n_req - r0 != 1) begin
            errors++; $display("FAIL best_counts: got dealloc=%0d req=%0d want 1 1", n_dealloc - d0, n_req - r0);
        end
    endtask

    task automatic test_flush();
        int unsigned d0 = n_dealloc;
        load(32'h0000_ABCF, 3'b010, 2'd3, 2'd0, 1'b1);
        mem_req_ready = 1; out_ready = 1;
        tick();  // ISSUE
        checks++;
        if ({mem_req_valid, mem_flush} !== 2'b11) begin errors++; $display("FAIL flush_issue: got %b want 11", {mem_req_valid, mem_flush}); end
        checks++;
        if (mem_addr !== 32'h0000_ABC0) begin errors++; $display("FAIL flush_addr: got %h want 0000abc0", mem_addr); end
        tick();  // WAIT
        mem_resp_valid = 1; mem_resp_nack = 0; mem_resp_data = 128'hDEAD;
        #1;
        checks++;
        if (q_dealloc !== 1'b1) begin errors++; $display("FAIL flush_dealloc: got %b want 1", q_dealloc); end
        q_valid = 0;
        tick();
        mem_resp_valid = 0;
        checks++;
        if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL flush_no_deliver: got %b want 00", {out_valid, busy}); end
        tick();
        checks++;
        if (out_valid !== 1'b0 || n_dealloc - d0 != 1) begin
            errors++; $display("FAIL flush_after: got out_valid=%b dealloc=%0d want 0 1", out_valid, n_dealloc - d0);
        end
    endtask

    task automatic test_nack(input int unsigned nacks, input logic exp_err);
        int unsigned d0 = n_dealloc;
        int unsigned r0 = n_req;
        logic [127:0] d = 128'h5555_AAAA_0000_FFFF_1234_5678_9ABC_DEF0;
        load(32'h2000_0040, 3'b001, 2'd1, 2'd2, 1'b0);
        mem_req_ready = 1; out_ready = 1;
        tick();  // ISSUE
        for (int unsigned k = 0; k < nacks; k++) begin
            tick();  // WAIT
            mem_resp_valid = 1; mem_resp_nack = 1; mem_resp_data = 128'hBAD;
            tick();
            mem_resp_valid = 0; mem_resp_nack = 0;
        end
        if (!exp_err) begin
            tick();  // WAIT after final reissue
            mem_resp_valid = 1; mem_resp_nack = 0; mem_resp_data = d;
            tick();
            mem_resp_valid = 0;
        end
        checks++;
        if ({out_valid, out_err} !== {1'b1, exp_err}) begin
            errors++; $display("FAIL nack%0d_deliver: got %b want %b", nacks, {out_valid, out_err}, {1'b1, exp_err});
        end
        checks++;
        if (out_data !== (exp_err ? 128'h0 : d)) begin
            errors++; $display("FAIL nack%0d_data: got %h want %h", nacks, out_data, exp_err ? 128'h0 : d);
        end
        q_valid = 0;
        tick();
        checks++;
        if (n_req - r0 != 4 || n_dealloc - d0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL nack%0d_counts: got req=%0d dealloc=%0d busy=%b want 4 1 0",
                               nacks, n_req - r0, n_dealloc - d0, busy);
        end
    endtask

    task automatic test_timeout(input logic resp_at_expiry);
        logic [127:0] d = 128'hCAFE_F00D_0000_0000_0000_0000_BEEF_0001;
        load(32'h3000_0008, 3'b011, 2'd0, 2'd3, 1'b0);
        mem_req_ready = 1; out_ready = 1;
        tick();  // ISSUE
        tick();  // WAIT cycle 0
        repeat (254) tick();  // WAIT cycle 254: expiry cycle
        checks++;
        if ({busy, out_valid, mem_req_valid} !== 3'b100) begin
            errors++; $display("FAIL tmo%0d_still_wait: got %b want 100", resp_at_expiry, {busy, out_valid, mem_req_valid});
        end
        if (resp_at_expiry) begin
            mem_resp_valid = 1; mem_resp_nack = 0; mem_resp_data = d;
        end
        tick();
        mem_resp_valid = 0;
        checks++;
        if ({out_valid, out_err, out_dest} !== {1'b1, !resp_at_expiry, 2'd3}) begin
            errors++; $display("FAIL tmo%0d_deliver: got %b want %b", resp_at_expiry,
                               {out_valid, out_err, out_dest}, {1'b1, !resp_at_expiry, 2'd3});
        end
        checks++;
        if (out_data !== (resp_at_expiry ? d : 128'h0)) begin
            errors++; $display("FAIL tmo%0d_data: got %h want %h", resp_at_expiry, out_data, resp_at_expiry ? d : 128'h0);
        end
        q_valid = 0;
        tick();
    endtask

    task automatic test_stall();
        int unsigned d0 = n_dealloc;
        int unsigned r0 = n_req;
        int unsigned bad = 0;
        logic [127:0] d = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        load(32'h4444_555F, 3'b111, 2'd2, 2'd2, 1'b0);
        mem_req_ready = 0; out_ready = 0;
        tick();  // ISSUE
        q_addr = 32'hFFFF_FFFF; q_op = 3'b000;
        for (int unsigned i = 0; i < 5; i++) begin
            if ({mem_req_valid, mem_addr, mem_op} !== {1'b1, 32'h4444_5550, 3'b111}) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_req_hold: got %0d bad cycles want 0", bad); end
        mem_req_ready = 1;
        tick();  // WAIT
        checks++;
        if (n_req - r0 != 1) begin errors++; $display("FAIL stall_req_count: got %0d want 1", n_req - r0); end
        mem_resp_valid = 1; mem_resp_nack = 0; mem_resp_data = d;
        tick();  // DELIVER
        mem_resp_valid = 0; mem_resp_data = '0;
        bad = 0;
        for (int unsigned i = 0; i < 3; i++) begin
            if ({out_valid, q_dealloc} !== 2'b10 || out_data !== d) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL stall_out_hold: got %0d bad cycles want 0", bad); end
        out_ready = 1;
        #1;
        checks++;
        if (q_dealloc !== 1'b1) begin errors++; $display("FAIL stall_dealloc: got %b want 1", q_dealloc); end
        q_valid = 0;
        tick();
        checks++;
        if (n_dealloc - d0 != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL stall_retire: got dealloc=%0d busy=%b want 1 0", n_dealloc - d0, busy);
        end
    endtask

    task automatic test_reset_mid();
        int unsigned d0 = n_dealloc;
        logic [174:0] outs;
        logic [127:0] d = 128'h0F0F_0F0F_F0F0_F0F0_0F0F_0F0F_F0F0_F0F0;
        load(32'h6000_0004, 3'b100, 2'd1, 2'd1, 1'b0);
        mem_req_ready = 1; out_ready = 1;
        tick();  // ISSUE
        tick();  // WAIT
        rst = 1;
        #1;
        outs = {q_dealloc, mem_req_valid, mem_addr, mem_op, mem_flush, mem_tag,
                out_valid, out_src, out_dest, out_data, out_err, busy};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL midrst_outputs: got %h want 0", outs); end
        q_valid = 0;
        tick();
        rst = 0;
        mem_resp_valid = 1; mem_resp_nack = 0; mem_resp_data = 128'hBEEF;
        tick();
        tick();
        mem_resp_valid = 0;
        checks++;
        if ({busy, out_valid} !== 2'b00 || n_dealloc != d0) begin
            errors++; $display("FAIL midrst_ignore: got busy=%b out_valid=%b dealloc=%0d want 0 0 0",
                               busy, out_valid, n_dealloc - d0);
        end
        load(32'h5000_0021, 3'b110, 2'd3, 2'd1, 1'b0);
        tick();  // ISSUE
        checks++;
        if ({mem_req_valid, mem_addr, mem_tag} !== {1'b1, 32'h5000_0020, 2'd3}) begin
            errors++; $display("FAIL midrst_restart_req: got %b %h %b want 1 50000020 11", mem_req_valid, mem_addr, mem_tag);
        end
        tick();  // WAIT
        mem_resp_valid = 1; mem_resp_nack = 0; mem_resp_data = d;
        tick();  // DELIVER
        mem_resp_valid = 0;
        checks++;
        if ({out_valid, out_err} !== 2'b10 || out_data !== d) begin
            errors++; $display("FAIL midrst_restart_data: got %b %h want 10 %h", {out_valid, out_err}, out_data, d);
        end
        q_valid = 0;
        tick();
        checks++;
        if (n_dealloc - d0 != 1) begin errors++; $display("FAIL midrst_dealloc: got %0d want 1", n_dealloc - d0); end
    endtask

    initial begin
        test_reset();
        test_best_case();
        test_flush();
        test_nack(3, 1'b0);
        test_nack(4, 1'b1);
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
